// File: rtl/fpadd_share_pkg.sv
// Shared types and constants for the shared single-precision adder front end.
package fpadd_share_pkg;

  // Controller phases: grant, push operand A, push operand B, collect Z, hand back.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_WAIT_Z = 3'd3,
    ST_RETURN = 3'd4
  } state_t;

  // Special single-precision encodings that must pass through untouched.
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN     = 32'hFFC0_0000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;

endpackage

// File: rtl/fpadd_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first valid requester after rr_ptr, wrapping.
module rr_pick
  import fpadd_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  // Scan from farthest to nearest so the candidate closest after rr_ptr is written last.
  always_comb begin
    int cand;
    winner    = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[cand[IDX_W-1:0]]) begin
        winner    = cand[IDX_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpadd_share_ctrl.sv
// Time-shares one non-pipelined single-precision adder between NUM_REQ clients.
// One operation in flight at a time; the result goes back only to its owner.
//
// Handshakes: a transfer happens on the rising clk edge where the sender's
// valid/stb and the receiver's ready/ack are both high. Requester side uses
// req_valid/req_ready and resp_valid/resp_ready; adder side uses the
// stb/ack pairs for A, B and Z. Neither side may be assumed to respond within
// any bound, so the controller waits indefinitely in each phase.
module fpadd_share_ctrl
  import fpadd_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [31:0]             resp_z,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_id,
  output logic [31:0]             add_a,
  output logic                    add_a_stb,
  input  logic                    add_a_ack,
  output logic [31:0]             add_b,
  output logic                    add_b_stb,
  input  logic                    add_b_ack,
  input  logic [31:0]             add_z,
  input  logic                    add_z_stb,
  output logic                    add_z_ack,
  output state_t                  state_dbg
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic             any_valid;
  logic [31:0]      op_a, op_b;
  logic [31:0]      win_a, win_b;
  logic             grant, a_hs, b_hs, z_hs, r_hs;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Reset masks the grant so no operand is accepted while rst is high.
  assign grant = (state == ST_IDLE) && any_valid && !rst;
  assign a_hs  = add_a_stb & add_a_ack;
  assign b_hs  = add_b_stb & add_b_ack;
  assign z_hs  = add_z_stb & add_z_ack;
  assign r_hs  = resp_valid[grant_id] & resp_ready[grant_id];

  assign add_a     = op_a;
  assign add_b     = op_b;
  assign state_dbg = state;

  // Operand slice mux for the current winner.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        win_a = req_a[32*i +: 32];
        win_b = req_b[32*i +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: each phase advances only on its own handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any_valid) state_nxt = ST_SEND_A;
      ST_SEND_A: if (a_hs)      state_nxt = ST_SEND_B;
      ST_SEND_B: if (b_hs)      state_nxt = ST_WAIT_Z;
      ST_WAIT_Z: if (z_hs)      state_nxt = ST_RETURN;
      ST_RETURN: if (r_hs)      state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Combinational outputs: one-hot grant in IDLE, busy everywhere else.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
    busy = (state != ST_IDLE);
  end

  // Datapath and registered strobes; each strobe is raised on the edge that
  // enters its phase so it is already high in the first cycle of that phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= IDX_W'(NUM_REQ - 1);
      grant_id   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      add_a_stb  <= 1'b0;
      add_b_stb  <= 1'b0;
      add_z_ack  <= 1'b0;
      resp_valid <= '0;
      resp_z     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            op_a      <= win_a;
            op_b      <= win_b;
            grant_id  <= winner;
            add_a_stb <= 1'b1;
          end
        end
        ST_SEND_A: begin
          if (a_hs) begin
            add_a_stb <= 1'b0;
            add_b_stb <= 1'b1;
          end
        end
        ST_SEND_B: begin
          if (b_hs) begin
            add_b_stb <= 1'b0;
            add_z_ack <= 1'b1;
          end
        end
        ST_WAIT_Z: begin
          if (z_hs) begin
            add_z_ack            <= 1'b0;
            resp_z               <= add_z;
            resp_valid[grant_id] <= 1'b1;
          end
        end
        ST_RETURN: begin
          if (r_hs) begin
            resp_valid <= '0;
            rr_ptr     <= grant_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpadd_share_ctrl.sv
// Directed bench for fpadd_share_ctrl with a behavioural strobe/ack adder.
module tb_fpadd_share_ctrl;
  import fpadd_share_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [32*NUM_REQ-1:0] req_a, req_b;
  logic [31:0]           resp_z, add_a, add_b, add_z;
  logic                  busy;
  logic [IDX_W-1:0]      grant_id;
  logic                  add_a_stb, add_a_ack, add_b_stb, add_b_ack, add_z_stb, add_z_ack;
  state_t                state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int z_delay  = 1;
  int a_cnt = 0, b_cnt = 0, z_cnt = 0;

  logic [31:0]      exp_q[$];
  logic [IDX_W-1:0] idx_q[$];
  logic [IDX_W-1:0] grant_log[$];

  fpadd_share_ctrl #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_z     (resp_z),
    .resp_ready (resp_ready),
    .busy       (busy),
    .grant_id   (grant_id),
    .add_a      (add_a),
    .add_a_stb  (add_a_stb),
    .add_a_ack  (add_a_ack),
    .add_b      (add_b),
    .add_b_stb  (add_b_stb),
    .add_b_ack  (add_b_ack),
    .add_z      (add_z),
    .add_z_stb  (add_z_stb),
    .add_z_ack  (add_z_ack),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- hand-computed single-precision sums ----------------
  function automatic logic [31:0] fp_add_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;  // 1 + 2 = 3
      {32'h4000_0000, 32'hC000_0000}: return FP_POS_ZERO;    // 2 + -2 = +0
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;  // 1 + 1 = 2
      {32'h4040_0000, 32'h3F80_0000}: return 32'h4080_0000;  // 3 + 1 = 4
      {FP_POS_INF,    32'h3F80_0000}: return FP_POS_INF;     // inf + 1 = inf
      {FP_POS_INF,    32'hFF80_0000}: return FP_QNAN;        // inf + -inf = qNaN
      {32'h4080_0000, 32'h4080_0000}: return 32'h4100_0000;  // 4 + 4 = 8
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_valid[idx]      = 1'b1;
  endtask

  task automatic wait_resp(input int idx);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (resp_valid[idx]) ok = 1'b1;
    end
    if (!ok) check("timeout_resp", 32'd0, 32'd1);
  endtask

  task automatic wait_grants(input int n);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      tick();
      if (grant_log.size() >= n) ok = 1'b1;
    end
    if (!ok) check("timeout_grants", grant_log.size(), n);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) check("timeout_idle", 32'd0, 32'd1);
  endtask

  // ---------------- behavioural adder (strobe/ack, reset by rst) ----------------
  initial begin : adder_model
    int m_st, lat;
    logic [31:0] ma, mb, sa, sb;
    logic s_rst, s_ahs, s_bhs, s_zhs;
    add_a_ack = 1'b0; add_b_ack = 1'b0; add_z_stb = 1'b0; add_z = '0;
    m_st = 0; lat = 0; ma = '0; mb = '0;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_ahs = add_a_stb & add_a_ack;
      s_bhs = add_b_stb & add_b_ack;
      s_zhs = add_z_stb & add_z_ack;
      sa    = add_a;
      sb    = add_b;
      @(posedge clk);
      #1;
      if (s_rst) begin
        add_a_ack = 1'b0; add_b_ack = 1'b0; add_z_stb = 1'b0; add_z = '0; m_st = 0;
      end else begin
        case (m_st)
          0: begin add_a_ack = 1'b1; m_st = 1; end
          1: if (s_ahs) begin ma = sa; add_a_ack = 1'b0; add_b_ack = 1'b1; m_st = 2; end
          2: if (s_bhs) begin mb = sb; add_b_ack = 1'b0; lat = z_delay; m_st = 3; end
          3: if (lat > 1) lat--;
             else begin add_z = fp_add_ref(ma, mb); add_z_stb = 1'b1; m_st = 4; end
          4: if (s_zhs) begin add_z_stb = 1'b0; add_a_ack = 1'b1; m_st = 1; end
          default: m_st = 0;
        endcase
      end
    end
  end

  // ---------------- scoreboard / protocol monitor ----------------
  always @(negedge clk) begin : monitor
    int w;
    logic [31:0] e;
    logic [IDX_W-1:0] ii;
    if (rst) begin
      exp_q.delete();
      idx_q.delete();
      a_cnt = 0; b_cnt = 0; z_cnt = 0;
    end else begin
      check("stb_overlap", {31'd0, add_a_stb & add_b_stb}, 32'd0);
      check("zack_phase", {31'd0, add_z_ack & !(b_cnt == 1 && z_cnt == 0)}, 32'd0);
      check("resp_onehot", {31'd0, $countones(resp_valid) <= 1}, 32'd1);
      if (|(req_valid & req_ready)) begin
        check("grant_onehot", $countones(req_ready), 32'd1);
        w = 0;
        for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) w = k;
        exp_q.push_back(fp_add_ref(req_a[w*32 +: 32], req_b[w*32 +: 32]));
        idx_q.push_back(IDX_W'(w));
        grant_log.push_back(IDX_W'(w));
        a_cnt = 0; b_cnt = 0; z_cnt = 0;
      end
      if (|(resp_valid & resp_ready)) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          ii = idx_q.pop_front();
          check("resp_idx", {28'd0, resp_valid}, 32'd1 << ii);
          check("resp_z", resp_z, e);
          check("resp_grant_id", {30'd0, grant_id}, {30'd0, ii});
          check("a_xfers", a_cnt, 32'd1);
          check("b_xfers", b_cnt, 32'd1);
          check("z_xfers", z_cnt, 32'd1);
        end
      end
      if (add_a_stb & add_a_ack) a_cnt++;
      if (add_b_stb & add_b_ack) b_cnt++;
      if (add_z_stb & add_z_ack) z_cnt++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [IDX_W-1:0] exp_order3[5];
    logic [IDX_W-1:0] exp_order4[3];
    bit ok;
    exp_order3 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_order4 = '{2'd1, 2'd3, 2'd0};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = '1;

    // Reset state, with requests already pending.
    tick(); tick();
    req_valid = 4'b1010;
    @(negedge clk);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("rst_a_stb", {31'd0, add_a_stb}, 32'd0);
    check("rst_z_ack", {31'd0, add_z_ack}, 32'd0);
    check("rst_resp_z", resp_z, 32'd0);
    check("rst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    tick();
    req_valid = '0;
    rst = 1'b0;

    // Single op from requester 2: 1 + 2 = 3.
    tick();
    set_req(2, 32'h3F80_0000, 32'h4000_0000);
    @(negedge clk);
    check("t1_req_ready", {28'd0, req_ready}, 32'h4);
    tick();
    req_valid[2] = 1'b0;
    wait_resp(2);
    check("t1_resp_valid", {28'd0, resp_valid}, 32'h4);
    check("t1_resp_z", resp_z, 32'h4040_0000);
    check("t1_grant_id", {30'd0, grant_id}, 32'd2);
    tick();
    @(negedge clk);
    check("t1_resp_clear", {28'd0, resp_valid}, 32'd0);

    // Cancellation to +0 from requester 0; busy drops right after the response.
    tick();
    set_req(0, 32'h4000_0000, 32'hC000_0000);
    @(negedge clk);
    check("t2_req_ready", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid[0] = 1'b0;
    wait_resp(0);
    check("t2_resp_z", resp_z, FP_POS_ZERO);
    check("t2_busy_ret", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clk);
    check("t2_busy_idle", {31'd0, busy}, 32'd0);

    // All four held valid from reset: rotation 0,1,2,3,0.
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    grant_log.delete();
    set_req(0, 32'h3F80_0000, 32'h3F80_0000);
    set_req(1, 32'h4040_0000, 32'h3F80_0000);
    set_req(2, FP_POS_INF,    32'h3F80_0000);
    set_req(3, FP_POS_INF,    32'hFF80_0000);
    wait_grants(5);
    req_valid = '0;
    wait_idle();
    for (int k = 0; k < 5; k++) check("t3_order", {30'd0, grant_log[k]}, {30'd0, exp_order3[k]});

    // Backpressure on requester 1 while others wait.
    grant_log.delete();
    resp_ready[1] = 1'b0;
    tick();
    set_req(1, 32'h4080_0000, 32'h4080_0000);
    @(negedge clk);
    check("t4_req_ready", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid[1] = 1'b0;
    wait_resp(1);
    tick();
    set_req(0, 32'h3F80_0000, 32'h3F80_0000);
    set_req(3, FP_POS_INF, 32'h3F80_0000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t4_hold_valid", {28'd0, resp_valid}, 32'h2);
      check("t4_hold_z", resp_z, 32'h4100_0000);
      check("t4_no_grant", {28'd0, req_ready}, 32'd0);
    end
    tick();
    resp_ready[1] = 1'b1;
    wait_grants(2);
    req_valid[3] = 1'b0;
    wait_grants(3);
    req_valid[0] = 1'b0;
    wait_idle();
    for (int k = 0; k < 3; k++) check("t4_order", {30'd0, grant_log[k]}, {30'd0, exp_order4[k]});

    // Reset while waiting on Z: operation dropped, then a clean op.
    z_delay = 8;
    tick();
    set_req(0, 32'h3F80_0000, 32'h4000_0000);
    @(negedge clk);
    check("t5_req_ready", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid[0] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (add_z_ack) ok = 1'b1;
    end
    if (!ok) check("timeout_zack", 32'd0, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    check("t5_resp_valid", {28'd0, resp_valid}, 32'd0);
    check("t5_resp_z", resp_z, 32'd0);
    check("t5_z_ack", {31'd0, add_z_ack}, 32'd0);
    check("t5_stbs", {30'd0, add_a_stb, add_b_stb}, 32'd0);
    check("t5_grant_id", {30'd0, grant_id}, 32'd0);
    check("t5_add_a", add_a, 32'd0);
    check("t5_req_ready", {28'd0, req_ready}, 32'd0);
    tick();
    rst = 1'b0;
    z_delay = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t5_no_resp", {28'd0, resp_valid}, 32'd0);
    end
    tick();
    set_req(0, 32'h4040_0000, 32'h3F80_0000);
    @(negedge clk);
    check("t5_regrant", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid[0] = 1'b0;
    wait_resp(0);
    check("t5_resp_z_after", resp_z, 32'h4080_0000);
    wait_idle();

    check("sb_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpadd_share_ctrl.md
Name: fpadd_share_ctrl

Overview:
- Round-robin scheduler that time-shares one non-pipelined 32-bit IEEE-754 single-precision adder between NUM_REQ requesters.
- Accepts an operand pair from one requester and drives the adder's three-phase strobe/ack protocol (A, then B, then Z).
- Returns the result to the originating requester only.
- Sits between the FPU's client ports and the adder instance; exactly one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of grant index; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset; the same rst drives the adder.
- req_valid  in  NUM_REQ  per-requester operand pair valid.
- req_a  in  32*NUM_REQ  operand A; slice i = [32*i+31:32*i].
- req_b  in  32*NUM_REQ  operand B, same packing.
- req_ready  out  NUM_REQ  combinational; one-hot or zero; operand transfer on valid&ready edge.
- resp_valid  out  NUM_REQ  registered; one-hot or zero.
- resp_z  out  32  result, meaningful while any resp_valid bit is high.
- resp_ready  in  NUM_REQ  per-requester result accept.
- busy  out  1  high in every state except IDLE.
- grant_id  out  IDX_W  index of the current owner; holds its last value in IDLE.
- add_a  out  32  to adder input_a.
- add_a_stb  out  1  to adder input_a_stb.
- add_a_ack  in  1  from adder input_a_ack.
- add_b  out  32  to adder input_b.
- add_b_stb  out  1  to adder input_b_stb.
- add_b_ack  in  1  from adder input_b_ack.
- add_z  in  32  from adder output_z.
- add_z_stb  in  1  from adder output_z_stb.
- add_z_ack  out  1  to adder output_z_ack.

Behaviour:
- Reset values: state IDLE, every registered output 0, rr_ptr = NUM_REQ-1 so requester 0 has top priority first. req_ready is 0 during reset.
- States: IDLE, SEND_A, SEND_B, WAIT_Z, RETURN.
- IDLE:
  - Winner = first i with req_valid[i] set, searching from rr_ptr+1 upward and wrapping modulo NUM_REQ.
  - req_ready[winner] = 1 combinationally.
  - On that edge, capture req_a/req_b slices into op_a/op_b and set grant_id = winner, then go to SEND_A.
  - With no valid requests, stay in IDLE and hold req_ready = 0.
- SEND_A:
  - add_a = op_a, add_a_stb = 1 (registered, asserted from the first SEND_A cycle).
  - On the edge where add_a_stb and add_a_ack are both high, clear add_a_stb and go to SEND_B.
- SEND_B: same as SEND_A using op_b and the add_b_* signals; on completion go to WAIT_Z.
- WAIT_Z:
  - add_z_ack held at 1.
  - On the edge where add_z_stb and add_z_ack are both high, capture add_z into resp_z, clear add_z_ack, set resp_valid[grant_id], and go to RETURN.
- RETURN:
  - Hold resp_valid and resp_z stable.
  - On the edge where resp_valid[grant_id] and resp_ready[grant_id] are both high, clear resp_valid, set rr_ptr = grant_id, and go to IDLE.
- No timeout: the controller waits indefinitely on the adder or on the requester.
- Backpressure: while RETURN is stalled, no new grant is issued and req_ready stays 0.
- Requester-side latency is zero (combinational req_ready). One extra IDLE cycle is spent between consecutive operations.
- The controller does not inspect the value, so NaN, Inf and zero results pass through unmodified.
- Reset mid-operation:
  - Any state returns to IDLE.
  - The in-flight operation is discarded with no response issued.
  - rr_ptr returns to NUM_REQ-1; the adder is reset by the same rst.
- Simultaneous rst and handshake: rst wins.
- A requester dropping req_valid before grant is legal. The operand pair is latched at grant, so later changes to req_a/req_b are ignored.

Decomposition:
- Package fpadd_share_pkg holds:
  - the state enum (3-bit);
  - FP constants: positive zero 0x00000000, canonical quiet NaN 0xFFC00000, +Inf 0x7F800000 (used by the bench scoreboard).
- One sub-module, rr_pick:
  - combinational; inputs req_valid and rr_ptr;
  - outputs winner index and any_valid.
  - The pointer register stays in the parent.

Test Plan:
- Single op, requester 2: a=0x3F800000, b=0x40000000 -> req_ready[2] pulse, then resp_valid[2] with resp_z=0x40400000; grant_id=2; no other resp bits.
- Cancellation, requester 0: a=0x40000000, b=0xC0000000 -> resp_z=0x00000000 (positive zero); busy low again 1 cycle after the resp handshake.
- All four requesters held valid from reset -> grant order 0,1,2,3,0; each resp returns to the originating index only.
- resp_ready[1] held low for 10 cycles during RETURN -> resp_valid[1] and resp_z stable; req_ready stays 0 throughout despite other valid requests.
- rst pulsed while in WAIT_Z -> next cycle all outputs 0, state IDLE, no resp issued; the next request from requester 0 completes correctly.
- Handshake check (assertion): add_a_stb never overlaps add_b_stb; add_z_ack is high only in WAIT_Z; exactly one A/B/Z transaction per grant.
